// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions: sync-state encodings, default polynomial and the
// next-word function used by both the generator and this checker.
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int          LFSR_W     = 3;
    localparam logic [2:0]  LFSR_TAPS  = 3'b110;
    localparam int          LFSR_MAX_W = 8;

    // Generic Fibonacci step: shift left, feed back parity of tapped bits.
    // Callers zero-extend their word/taps to LFSR_MAX_W and truncate the result.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] q,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           w
    );
        logic [LFSR_MAX_W-1:0] mask;
        mask = LFSR_MAX_W'((32'd1 << w) - 32'd1);
        return ((q << 1) | {{(LFSR_MAX_W-1){1'b0}}, ^(q & taps)}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream-in / status-out bundle between an LFSR source and the checker.
interface lfsr_checker_if
    import lfsr_checker_pkg::*;
#(
    parameter int WIDTH = LFSR_W,
    parameter int CNT_W = 16
);
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       sync_state;

    modport master (
        output din_valid, din, clr_cnt,
        input  locked, err_pulse, err_cnt, sync_state
    );

    modport slave (
        input  din_valid, din, clr_cnt,
        output locked, err_pulse, err_cnt, sync_state
    );
endinterface

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment leaves the counter at 1 so that event is not lost.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             set,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Count events, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (set)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= i_inc ? CNT_W'(1) : '0;
        else if (i_inc && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: hunts for a seed word, verifies LOCK_CNT
// predicted words, then flywheels on its own prediction and counts errors.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int               WIDTH    = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               CNT_W    = 16
) (
    input  logic          clk,
    input  logic          set,
    lfsr_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(LOSS_CNT + 1);

    sync_state_t      r_state;
    logic [WIDTH-1:0] r_pred;
    logic [MW-1:0]    r_match;
    logic [SW-1:0]    r_miss;
    logic             r_locked;
    logic             r_err_pulse;

    logic [WIDTH-1:0] w_din_next;
    logic [WIDTH-1:0] w_pred_next;
    logic             w_din_zero;
    logic             w_hit;
    logic             w_err;

    assign w_din_next  = WIDTH'(lfsr_next(LFSR_MAX_W'(bus.din), LFSR_MAX_W'(TAPS), WIDTH));
    assign w_pred_next = WIDTH'(lfsr_next(LFSR_MAX_W'(r_pred),  LFSR_MAX_W'(TAPS), WIDTH));
    assign w_din_zero  = (bus.din == '0);
    assign w_hit       = (bus.din == r_pred);
    // Only mismatches seen while locked are errors; VERIFY misses just reseed.
    assign w_err       = bus.din_valid && (r_state == LOCKED) && !w_hit;

    // Sync FSM with prediction register and match/miss run counters.
    always_ff @(posedge clk) begin
        if (set) begin
            r_state     <= HUNT;
            r_pred      <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            if (bus.din_valid) begin
                case (r_state)
                    HUNT: begin
                        // All-zero is the LFSR lock-up word and can never seed.
                        if (!w_din_zero) begin
                            r_pred  <= w_din_next;
                            r_match <= '0;
                            r_state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (w_hit) begin
                            r_pred  <= w_din_next;
                            r_match <= r_match + MW'(1);
                            if (r_match == MW'(LOCK_CNT - 1)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_miss   <= '0;
                            end
                        end else if (!w_din_zero) begin
                            r_pred  <= w_din_next;
                            r_match <= '0;
                        end else begin
                            r_match <= '0;
                            r_state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: keep predicting from our own state so a
                        // corrupted word cannot drag the reference off course.
                        r_pred <= w_pred_next;
                        if (w_hit) begin
                            r_miss <= '0;
                        end else if (r_miss == SW'(LOSS_CNT - 1)) begin
                            r_miss   <= '0;
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                        end else begin
                            r_miss <= r_miss + SW'(1);
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .set   (set),
        .i_inc (w_err),
        .i_clr (bus.clr_cnt),
        .o_cnt (bus.err_cnt)
    );

    assign bus.locked     = r_locked;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.sync_state = r_state;
endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model predicts the outputs
// of each driven cycle, which are queued and compared after the clock edge.
// A second instance with a 4-bit counter checks saturation.
module tb_lfsr_checker;
    import lfsr_checker_pkg::*;

    logic clk = 1'b0;
    logic set = 1'b0;
    always #5 clk = ~clk;

    lfsr_checker_if #(.WIDTH(3), .CNT_W(16)) bus16 ();
    lfsr_checker_if #(.WIDTH(3), .CNT_W(4))  bus4 ();

    lfsr_checker #(.CNT_W(16)) dut16 (.clk(clk), .set(set), .bus(bus16));
    lfsr_checker #(.CNT_W(4))  dut4  (.clk(clk), .set(set), .bus(bus4));

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [15:0] c16;
        logic [3:0]  c4;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic seen_pulse = 1'b0;

    // reference model state
    int          m_st    = 0;
    logic [2:0]  m_pred  = 3'd0;
    int          m_match = 0;
    int          m_miss  = 0;
    logic        m_pulse = 1'b0;
    int          m_c16   = 0;
    int          m_c4    = 0;

    // Reference sequence written out as a table.
    function automatic logic [2:0] nx(input logic [2:0] q);
        case (q)
            3'b001: return 3'b010;
            3'b010: return 3'b101;
            3'b101: return 3'b011;
            3'b011: return 3'b111;
            3'b111: return 3'b110;
            3'b110: return 3'b100;
            3'b100: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic v, input logic [2:0] d, input logic c, input logic s);
        logic err;
        if (s) begin
            m_st = 0; m_pred = 3'd0; m_match = 0; m_miss = 0;
            m_pulse = 1'b0; m_c16 = 0; m_c4 = 0;
            return;
        end
        err = v && (m_st == 2) && (d != m_pred);
        m_pulse = err;
        if (c) begin
            m_c16 = err ? 1 : 0;
            m_c4  = err ? 1 : 0;
        end else if (err) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15) m_c4++;
        end
        if (!v) return;
        if (m_st == 0) begin
            if (d != 3'd0) begin m_pred = nx(d); m_match = 0; m_st = 1; end
        end else if (m_st == 1) begin
            if (d == m_pred) begin
                m_match++; m_pred = nx(d);
                if (m_match == 4) m_st = 2;
            end else if (d != 3'd0) begin
                m_pred = nx(d); m_match = 0;
            end else begin
                m_st = 0;
            end
        end else begin
            m_pred = nx(m_pred);
            if (!err) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss == 3) begin m_miss = 0; m_st = 0; end
            end
        end
    endtask

    task automatic step(input logic v, input logic [2:0] d, input logic c, input logic s);
        exp_t e;
        @(negedge clk);
        set = s;
        bus16.din_valid = v; bus4.din_valid = v;
        bus16.din = d;       bus4.din = d;
        bus16.clr_cnt = c;   bus4.clr_cnt = c;
        model(v, d, c, s);
        e.locked = (m_st == 2);
        e.pulse  = m_pulse;
        e.c16    = 16'(m_c16);
        e.c4     = 4'(m_c4);
        e.st     = 2'(m_st);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        seen_pulse = seen_pulse | bus16.err_pulse;
        chk("locked",    32'(bus16.locked),     32'(e.locked));
        chk("err_pulse", 32'(bus16.err_pulse),  32'(e.pulse));
        chk("err_cnt16", 32'(bus16.err_cnt),    32'(e.c16));
        chk("err_cnt4",  32'(bus4.err_cnt),     32'(e.c4));
        chk("state",     32'(bus16.sync_state), 32'(e.st));
        chk("lk_vs_st",  32'(bus16.locked),     32'(bus16.sync_state == 2'd2));
    endtask

    // Feed n words of the clean sequence starting at start.
    task automatic clean(input logic [2:0] start, input int n);
        logic [2:0] g;
        g = start;
        for (int i = 0; i < n; i++) begin
            step(1'b1, g, 1'b0, 1'b0);
            g = nx(g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        bus16.din_valid = 1'b0; bus4.din_valid = 1'b0;
        bus16.din = 3'd0;       bus4.din = 3'd0;
        bus16.clr_cnt = 1'b0;   bus4.clr_cnt = 1'b0;

        // 1: reset
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 3'd5, 1'b0, 1'b1);
        chk("t1_state", 32'(bus16.sync_state), 32'd0);

        // 2: clean stream from 001
        seen_pulse = 1'b0;
        clean(3'b001, 4);
        chk("t2_not_yet", 32'(bus16.locked), 32'd0);
        clean(3'b111, 10);
        chk("t2_locked", 32'(bus16.locked), 32'd1);
        chk("t2_cnt", 32'(bus16.err_cnt), 32'd0);
        chk("t2_nopulse", 32'(seen_pulse), 32'd0);

        // 3: one bad word (111 where 011 due)
        for (int i = 0; i < 8 && m_pred != 3'b011; i++) step(1'b1, m_pred, 1'b0, 1'b0);
        step(1'b1, 3'b111, 1'b0, 1'b0);
        chk("t3_pulse", 32'(bus16.err_pulse), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, m_pred, 1'b0, 1'b0);
        chk("t3_cnt", 32'(bus16.err_cnt), 32'd1);
        chk("t3_locked", 32'(bus16.locked), 32'd1);

        // 4: loss of lock after 3 consecutive errors, then relock
        step(1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, ~m_pred, 1'b0, 1'b0);
        chk("t4_cnt", 32'(bus16.err_cnt), 32'd3);
        chk("t4_unlocked", 32'(bus16.locked), 32'd0);
        clean(3'b101, 5);
        chk("t4_relock", 32'(bus16.locked), 32'd1);

        // 5: zeros in HUNT, then valid gaps in a locked stream
        step(1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 3'd0, 1'b0, 1'b0);
        chk("t5_hunt", 32'(bus16.sync_state), 32'd0);
        clean(3'b110, 5);
        seen_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, m_pred, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        end
        chk("t5_gap_lock", 32'(bus16.locked), 32'd1);
        chk("t5_gap_pulse", 32'(seen_pulse), 32'd0);

        // 6: reset mid-lock, clear+error, saturation
        step(1'b1, m_pred, 1'b0, 1'b1);
        chk("t6_rst_lock", 32'(bus16.locked), 32'd0);
        clean(3'b011, 5);
        step(1'b1, ~m_pred, 1'b1, 1'b0);
        chk("t6_clr_err", 32'(bus16.err_cnt), 32'd1);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, ~m_pred, 1'b0, 1'b0);
            step(1'b1, m_pred, 1'b0, 1'b0);
        end
        chk("t6_sat4", 32'(bus4.err_cnt), 32'd15);
        chk("t6_cnt16", 32'(bus16.err_cnt), 32'd20);
        chk("t6_locked", 32'(bus16.locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
